stopwatch_bcd: RTL and testbench

- Consumes the slow square wave produced by the lab clock divider. Each rising edge of that wave counts as one 0.1 s unit.
- Maintains an M:SS.t stopwatch in four BCD digits with start/stop and clear control.
- Runs entirely in the system clock domain. The divided wave is treated as a data input that is synchronized and edge-detected, never used as a clock.
- Digit outputs feed the seven-segment display driver.

---
 rtl/stopwatch_bcd_pkg.sv | 16 +
 rtl/stopwatch_bcd_sync_edge_detect.sv | 32 +++
 rtl/stopwatch_bcd.sv | 123 ++++++++++++
 tb/tb_stopwatch_bcd.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_bcd_pkg.sv
// Shared definitions for the BCD stopwatch.
//   state_t       : stopwatch control states
//   BCD_DIGIT_MAX : highest value of a decimal digit
//   BCD_TENS_MAX  : highest value of the seconds-tens digit
package stopwatch_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] BCD_TENS_MAX  = 4'd5;

endpackage

// File: rtl/stopwatch_bcd_sync_edge_detect.sv
// Input synchronizer with rising-edge detector.
//   clk_in    : system clock
//   rst_n     : asynchronous active-low reset
//   d_in      : asynchronous level input
//   pulse_out : one-cycle pulse per synchronized rising edge of d_in
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic d_in,
    output logic pulse_out
);
    import stopwatch_bcd_pkg::*;

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d_in};
            hist <= sync[SYNC_STAGES-1];
        end
    end

    // Pulse is decoded from flops only, so it is glitch-free inside clk_in.
    assign pulse_out = sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/stopwatch_bcd.sv
// M:SS.t stopwatch kept as four BCD digits.
//   clk_in     : system clock
//   rst_n      : asynchronous active-low reset
//   tick_in    : divided square wave, each rising edge is 0.1 s
//   start_stop : button level, each rising edge toggles run/pause
//   clear      : synchronous clear of time and state while high
//   digit0..3  : tenths, seconds ones, seconds tens, minutes (BCD)
//   running    : high while in RUNNING
//   overflow   : sticky, set when time wraps from MAX_MIN:59.9
//
// state   | meaning
// --------+------------------------------------------
// IDLE    | cleared, waiting for first start press
// RUNNING | ticks advance the time
// PAUSED  | time held, next press resumes
module stopwatch_bcd
    import stopwatch_bcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 9
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       running,
    output logic       overflow
);

    localparam logic [3:0] MAX_MIN_BCD = 4'(MAX_MIN);

    logic   tick_p;
    logic   ss_p;
    state_t state;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .d_in      (tick_in),
        .pulse_out (tick_p)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .d_in      (start_stop),
        .pulse_out (ss_p)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
            digit0   <= 4'd0;
            digit1   <= 4'd0;
            digit2   <= 4'd0;
            digit3   <= 4'd0;
        end else if (clear) begin
            state    <= IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
            digit0   <= 4'd0;
            digit1   <= 4'd0;
            digit2   <= 4'd0;
            digit3   <= 4'd0;
        end else begin
            // Counting looks at the current state, so a tick coinciding
            // with the pausing press still counts, and one coinciding
            // with the starting press does not.
            if (tick_p && state == RUNNING) begin
                if (digit0 == BCD_DIGIT_MAX) begin
                    digit0 <= 4'd0;
                    if (digit1 == BCD_DIGIT_MAX) begin
                        digit1 <= 4'd0;
                        if (digit2 == BCD_TENS_MAX) begin
                            digit2 <= 4'd0;
                            if (digit3 == MAX_MIN_BCD) begin
                                digit3   <= 4'd0;
                                overflow <= 1'b1;
                            end else begin
                                digit3 <= digit3 + 4'd1;
                            end
                        end else begin
                            digit2 <= digit2 + 4'd1;
                        end
                    end else begin
                        digit1 <= digit1 + 4'd1;
                    end
                end else begin
                    digit0 <= digit0 + 4'd1;
                end
            end

            if (ss_p) begin
                case (state)
                    IDLE: begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end
                    RUNNING: begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                    PAUSED: begin
                        state   <= RUNNING;
                        running <= 1'b1;
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd.sv
module tb_stopwatch_bcd;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       start_stop;
    logic       clear;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       running, overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: elapsed tenths since last clear, plus run flag.
    localparam int PERIOD = 10 * 600;   // MAX_MIN=9 -> 10 minutes of tenths
    int m_count = 0;
    bit m_run   = 1'b0;

    stopwatch_bcd dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .digit0     (digit0),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .running    (running),
        .overflow   (overflow)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] pack(input logic [15:0] d, input bit r, input bit o);
        return {d, r, o};
    endfunction

    function automatic logic [17:0] model_exp();
        int t;
        logic [15:0] d;
        t = m_count % PERIOD;
        d = {4'(t / 600), 4'((t / 100) % 6), 4'((t / 10) % 10), 4'(t % 10)};
        return pack(d, m_run, m_count >= PERIOD);
    endfunction

    task automatic chk(input string name, input logic [17:0] exp);
        logic [17:0] act;
        act = {digit3, digit2, digit1, digit0, running, overflow};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got digits=%h run=%b ovf=%b want digits=%h run=%b ovf=%b",
                     name, act[17:2], act[1], act[0], exp[17:2], exp[1], exp[0]);
        end
    endtask

    task automatic do_tick();
        @(negedge clk_in) tick_in = 1'b1;
        repeat (2) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (2) @(negedge clk_in);
        if (m_run) m_count++;
    endtask

    task automatic do_press();
        @(negedge clk_in) start_stop = 1'b1;
        repeat (3) @(negedge clk_in);
        start_stop = 1'b0;
        repeat (3) @(negedge clk_in);
        m_run = !m_run;
    endtask

    task automatic do_clear();
        @(negedge clk_in) clear = 1'b1;
        repeat (2) @(negedge clk_in);
        clear = 1'b0;
        @(negedge clk_in);
        m_count = 0;
        m_run   = 1'b0;
    endtask

    typedef struct {
        bit          press;
        int          n_ticks;
        bit          clr;
        logic [15:0] exp_d;
        bit          exp_run;
        bit          exp_ovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b0,  3, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 10, 1'b0, 16'h0010, 1'b1, 1'b0};
        vecs[2] = '{1'b1,  7, 1'b0, 16'h0010, 1'b0, 1'b0};
        vecs[3] = '{1'b1,  5, 1'b0, 16'h0015, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 95, 1'b0, 16'h0110, 1'b1, 1'b0};
        vecs[5] = '{1'b0,  0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[6] = '{1'b1,  4, 1'b0, 16'h0004, 1'b1, 1'b0};

        rst_n = 1'b0; tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0;

        // Reset held with inputs toggling
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            tick_in    = ~tick_in;
            start_stop = ~start_stop;
        end
        chk("reset_hold", pack(16'h0000, 1'b0, 1'b0));
        @(negedge clk_in) tick_in = 1'b0; start_stop = 1'b0;
        @(negedge clk_in) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) do_tick();
        chk("idle_ticks", pack(16'h0000, 1'b0, 1'b0));

        // Table vectors
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].press) do_press();
            for (int j = 0; j < vecs[i].n_ticks; j++) do_tick();
            if (vecs[i].clr) do_clear();
            chk($sformatf("vec%0d", i), pack(vecs[i].exp_d, vecs[i].exp_run, vecs[i].exp_ovf));
        end

        // Pause/resume sequence
        do_clear();
        do_press();
        for (int i = 0; i < 5; i++) do_tick();
        do_press();
        chk("pause_at_5", pack(16'h0005, 1'b0, 1'b0));
        for (int i = 0; i < 7; i++) do_tick();
        chk("paused_hold", pack(16'h0005, 1'b0, 1'b0));
        do_press();
        for (int i = 0; i < 3; i++) do_tick();
        chk("resume_8", pack(16'h0008, 1'b1, 1'b0));

        // First-increment latency: sampled at edge k, update at edge k+2
        do_clear();
        do_press();
        @(negedge clk_in) tick_in = 1'b1;
        @(posedge clk_in);
        @(posedge clk_in); #1;
        chk("latency_k1", pack(16'h0000, 1'b1, 1'b0));
        @(posedge clk_in); #1;
        chk("latency_k2", pack(16'h0001, 1'b1, 1'b0));
        repeat (2) @(negedge clk_in);
        tick_in = 1'b0;
        repeat (2) @(negedge clk_in);
        m_count++;

        // Rollover
        do_clear();
        do_press();
        for (int i = 0; i < PERIOD - 1; i++) do_tick();
        chk("max_time", pack(16'h9599, 1'b1, 1'b0));
        do_tick();
        chk("wrap", pack(16'h0000, 1'b1, 1'b1));
        do_tick();
        chk("wrap_plus1", pack(16'h0001, 1'b1, 1'b1));
        do_clear();
        chk("wrap_clear", pack(16'h0000, 1'b0, 1'b0));

        // Simultaneous tick and press
        do_press();
        for (int i = 0; i < 3; i++) do_tick();
        @(negedge clk_in) tick_in = 1'b1; start_stop = 1'b1;
        repeat (3) @(negedge clk_in);
        tick_in = 1'b0; start_stop = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("sim_running", pack(16'h0004, 1'b0, 1'b0));
        @(negedge clk_in) tick_in = 1'b1; start_stop = 1'b1;
        repeat (3) @(negedge clk_in);
        tick_in = 1'b0; start_stop = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("sim_paused", pack(16'h0004, 1'b1, 1'b0));
        @(negedge clk_in) tick_in = 1'b1; start_stop = 1'b1; clear = 1'b1;
        repeat (4) @(negedge clk_in);
        tick_in = 1'b0; start_stop = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("sim_clear", pack(16'h0000, 1'b0, 1'b0));
        m_count = 0; m_run = 1'b0;

        // Reset mid-run, between clock edges
        do_press();
        for (int i = 0; i < 127; i++) do_tick();
        chk("at_12_7", pack(16'h0127, 1'b1, 1'b0));
        @(posedge clk_in); #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", pack(16'h0000, 1'b0, 1'b0));
        #1 rst_n = 1'b1;
        m_count = 0; m_run = 1'b0;
        repeat (2) @(negedge clk_in);
        do_press();
        for (int i = 0; i < 2; i++) do_tick();
        chk("after_reset", pack(16'h0002, 1'b1, 1'b0));

        // Random operations against the model
        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 2) do_press();
            else if (op < 9) do_tick();
            else do_clear();
            chk($sformatf("rand%0d", i), model_exp());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
